// File: rtl/dds_pkg.sv
// Shared encodings for the DDS sweep generator:
// waveform select codes and FSM state codes.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SAW    = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_SWEEP = 2'b10
  } state_e;

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine magnitude ROM, registered read (1 cycle).
// Ports: clk, rst (async high), addr in, mag out.
module sine_qlut #(
  parameter int QA_W  = 10,
  parameter int MAG_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [QA_W-1:0]  addr,
  output logic [MAG_W-1:0] mag
);

  localparam int  DEPTH = 1 << QA_W;
  localparam real PI    = 3.14159265358979323846;
  localparam real PEAK  = real'((1 << MAG_W) - 1);

  logic [MAG_W-1:0] rom [DEPTH];
  logic [MAG_W-1:0] mag_d;
  logic [MAG_W-1:0] mag_q;

  // Half-sample offset keeps the table symmetric, so
  // mirroring by bit inversion is exact.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real ANG =
      2.0 * PI * (real'(k) + 0.5) / real'(4 * DEPTH);
    localparam int VAL = $rtoi(PEAK * $sin(ANG) + 0.5);
    assign rom[k] = MAG_W'(VAL);
  end

  always_comb mag_d = rom[addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mag_q <= '0;
    else     mag_q <= mag_d;
  end

  assign mag = mag_q;

endmodule

// File: rtl/dds_sweep_gen.sv
// DDS generator with optional linear frequency sweep.
// Ports: start/stop/sweep_en control, wave/amp/phase live,
// cfg_load latches freq_start/stop/step + step_div,
// data_out/data_valid sample, busy, sweep_done, cur_freq.
module dds_sweep_gen
  import dds_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int AMP_W  = 9
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              stop,
  input  logic              sweep_en,
  input  logic [1:0]        wave_sel,
  input  logic [AMP_W-1:0]  amp_ctl,
  input  logic [ADDR_W-1:0] phase_ctl,
  input  logic              cfg_load,
  input  logic [ACC_W-1:0]  freq_start,
  input  logic [ACC_W-1:0]  freq_stop,
  input  logic [ACC_W-1:0]  freq_step,
  input  logic [15:0]       step_div,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              sweep_done,
  output logic [ACC_W-1:0]  cur_freq
);

  localparam int PW = DATA_W + AMP_W;
  localparam logic [DATA_W-1:0] HALF = DATA_W'(1 << (DATA_W-1));
  localparam logic [AMP_W-1:0]  UNITY = AMP_W'(1 << (AMP_W-1));

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   cur_q, cur_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]   fstart_q, fstart_d;
  logic [ACC_W-1:0]   fstop_q, fstop_d;
  logic [ACC_W-1:0]   fstep_q, fstep_d;
  logic [15:0]        div_q, div_d;
  logic               pend_q, pend_d;
  logic               done_q, done_d;

  logic               v1_q, v1_d, v2_q, v2_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  p_q, p_d;
  logic [DATA_W-1:0]  shape_q, shape_d;
  logic               sine_q, sine_d;
  logic               msb_q, msb_d;
  logic [DATA_W-1:0]  dout_q, dout_d;

  logic               is_busy, kill;
  logic [ACC_W:0]     sum;
  logic [ADDR_W-3:0]  q_addr;
  logic [DATA_W-2:0]  mag;
  logic [DATA_W-1:0]  tri_x, shape_v;
  logic [AMP_W-1:0]   amp_eff;
  logic [PW-1:0]      prod;

  sine_qlut #(
    .QA_W  (ADDR_W-2),
    .MAG_W (DATA_W-1)
  ) u_lut (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .addr (q_addr),
    .mag  (mag)
  );

  always_comb begin
    is_busy  = state_q != ST_IDLE;
    kill     = is_busy && stop;
    sum      = {1'b0, cur_q} + {1'b0, fstep_q};
    state_d  = state_q;
    acc_d    = acc_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    fstart_d = fstart_q;
    fstop_d  = fstop_q;
    fstep_d  = fstep_q;
    div_d    = div_q;
    pend_d   = 1'b0;
    done_d   = pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          fstart_d = freq_start;
          fstop_d  = freq_stop;
          fstep_d  = freq_step;
          div_d    = step_div;
        end
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          cur_d = fstart_q;
          if (!sweep_en) begin
            state_d = ST_RUN;
          end else if (fstart_q >= fstop_q) begin
            // Degenerate sweep: jump to the end, pulse next cycle.
            cur_d   = fstop_q;
            state_d = ST_RUN;
            pend_d  = 1'b1;
          end else begin
            state_d = ST_SWEEP;
          end
        end
      end
      ST_RUN: acc_d = acc_q + cur_q;
      ST_SWEEP: begin
        acc_d = acc_q + cur_q;
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (sum >= {1'b0, fstop_q}) begin
            cur_d   = fstop_q;
            done_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            cur_d = sum[ACC_W-1:0];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    v1_d    = is_busy && !kill;
    v2_d    = v1_q && !kill;
    valid_d = v2_q && !kill;
    p_d     = '0;
    if (v1_d) p_d = acc_q[ACC_W-1 -: ADDR_W] + phase_ctl;

    q_addr = p_q[ADDR_W-2] ? ~p_q[ADDR_W-3:0]
                           : p_q[ADDR_W-3:0];
    tri_x  = p_q[ADDR_W-2 -: DATA_W];
    msb_d  = p_q[ADDR_W-1];
    sine_d = 1'b0;
    shape_d = '0;
    unique case (wave_e'(wave_sel))
      WAVE_SINE:   sine_d  = 1'b1;
      WAVE_SQUARE: shape_d = msb_d ? '0 : '1;
      WAVE_TRI:    shape_d = msb_d ? ~tri_x : tri_x;
      WAVE_SAW:    shape_d = p_q[ADDR_W-1 -: DATA_W];
    endcase

    if (sine_q) shape_v = msb_q ? HALF - 8'(1) - DATA_W'(mag)
                                : HALF + DATA_W'(mag);
    else        shape_v = shape_q;
    amp_eff = (amp_ctl > UNITY) ? UNITY : amp_ctl;
    prod    = PW'(shape_v) * PW'(amp_eff);
    dout_d  = valid_d ? DATA_W'(prod >> (AMP_W-1)) : '0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      div_q    <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      valid_q  <= 1'b0;
      p_q      <= '0;
      shape_q  <= '0;
      sine_q   <= 1'b0;
      msb_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      fstart_q <= fstart_d;
      fstop_q  <= fstop_d;
      fstep_q  <= fstep_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      valid_q  <= valid_d;
      p_q      <= p_d;
      shape_q  <= shape_d;
      sine_q   <= sine_d;
      msb_q    <= msb_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = is_busy;
  assign sweep_done = done_q;
  assign cur_freq   = cur_q;

endmodule

// File: doc/dds_sweep_gen.md
DDS_SWEEP_GEN -- requirements
Module: dds_sweep_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 32, meaning phase accumulator width.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning phase index width; ADDR_W >= DATA_W+1.
REQ-003 SHALL have parameter DATA_W, default 8, meaning output sample width, unsigned offset-binary.
REQ-004 SHALL have parameter AMP_W, default 9, meaning amplitude width; unity gain = 2^(AMP_W-1).
REQ-005 SHALL have ports, one per line:
- sys_clk  in  1  sole clock, rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse, begin generation.
- stop  in  1  pulse, abort to idle.
- sweep_en  in  1  sampled with start: 1 = linear sweep, 0 = fixed frequency.
- wave_sel  in  2  00 sine, 01 square, 10 triangle, 11 sawtooth; live.
- amp_ctl  in  AMP_W  amplitude; live.
- phase_ctl  in  ADDR_W  phase offset; live.
- cfg_load  in  1  pulse, latches freq_start/freq_stop/freq_step/step_div.
- freq_start, freq_stop, freq_step  in  ACC_W each  tuning words.
- step_div  in  16  cycles between sweep steps, minus one.
- data_out  out  DATA_W  sample.
- data_valid  out  1  data_out meaningful.
- busy  out  1  state != IDLE.
- sweep_done  out  1  one-cycle pulse at sweep end.
- cur_freq  out  ACC_W  current tuning word.

Function
REQ-006 SHALL implement FSM IDLE, RUN, SWEEP; reset state IDLE.
REQ-007 SHALL, in IDLE, on start sampled at edge T: enter SWEEP if sweep_en else RUN; cur_freq <= freq_start; accumulator <= 0.
REQ-008 SHALL, in RUN/SWEEP, add cur_freq to accumulator each cycle, modulo 2^ACC_W.
REQ-009 SHALL, on stop in RUN/SWEEP: go to IDLE next edge, clear accumulator; data_valid and data_out 0 from that edge; stop wins over simultaneous start.
REQ-010 SHALL ignore start while busy; SHALL ignore cfg_load unless in IDLE.
REQ-011 SHALL, in SWEEP, count cycles from 0 on entry; when count == step_div, clear count and set cur_freq <= min(cur_freq + freq_step, freq_stop), sum computed in ACC_W+1 bits.
REQ-012 SHALL, when that update reaches freq_stop, pulse sweep_done on the same edge and enter RUN, holding freq_stop.
REQ-013 SHALL, on start with sweep_en=1 and freq_start >= freq_stop, set cur_freq <= freq_stop, enter RUN, and pulse sweep_done at T+1; freq_step = 0 sweeps indefinitely.
REQ-014 SHALL form phase index p = acc[ACC_W-1 -: ADDR_W] + phase_ctl, modulo 2^ADDR_W.
REQ-015 SHALL shape waveforms:
- saw = p[ADDR_W-1 -: DATA_W].
- square = all-ones when p MSB = 0, else 0.
- triangle: x = p[ADDR_W-2 -: DATA_W]; output x when MSB = 0, else ~x.
- sine: m = quarter-table magnitude, mirrored on p[ADDR_W-2]; output 2^(DATA_W-1)+m when MSB = 0, else 2^(DATA_W-1)-1-m.
REQ-016 SHALL fill sine entries m[k] = round((2^(DATA_W-1)-1)*sin(2*pi*(k+0.5)/2^ADDR_W)), k = 0..2^(ADDR_W-2)-1.
REQ-017 SHALL compute data_out = (shape * min(amp_ctl, 2^(AMP_W-1))) >> (AMP_W-1).
REQ-018 SHALL pipeline phase add, shape and scale as one register each: acc value at edge T appears on data_out at T+3; data_valid rises at T+3 after start.

Reset
REQ-019 SHALL, on sys_rst assertion, immediately force: state IDLE; accumulator, cur_freq, cfg registers, pipeline and all outputs 0.
REQ-020 SHALL, on reset mid-sweep, leave no residual sweep_done pulse or valid data after release.

Structure
REQ-021 SHALL place the wave_sel encodings and FSM state encodings in shared package dds_pkg.
REQ-022 SHALL implement the quarter-wave table as sub-module sine_qlut: registered read, one-cycle latency, parameters ADDR_W-2 and DATA_W-1.

Verification
REQ-023 Reset with all inputs driven -> every output 0, busy 0.
REQ-024 Saw, freq_start = 2^24, phase 0, amp 256, start at T -> data_out 0 at T+3, then +1 per cycle, 255 wraps to 0; data_valid from T+3.
REQ-025 Square, freq 2^24, amp 128 -> data_out 127 for 128 cycles, then 0 for 128 cycles; amp 300 behaves as 256, giving 255.
REQ-026 Sweep: start = 2^24, step = 2^24, stop = 5*2^24, step_div = 3 -> cur_freq steps at T+4/8/12/16; sweep_done pulses at T+16; state RUN.
REQ-027 In RUN, start and stop in the same cycle -> IDLE, data_valid 0 next edge; cfg_load while busy leaves the cfg registers unchanged.
REQ-028 sys_rst mid-sweep at cycle T+6, then restart -> sweep restarts from freq_start with full timing.
